// File: rtl/mux_select_gpio_sequencer.sv
// Maps a mux select address to a GPIO code with range check, settle/hold sequencing and strobe.
// Optional: define MUX_GPIO_GRAY_EN to drive the code Gray-encoded.
module mux_select_gpio_sequencer #(
  parameter int ADDR_W     = 5,
  parameter int GPIO_W     = 4,
  parameter int BASE       = 'h10,
  parameter int SETTLE_CYC = 2,
  parameter int HOLD_CYC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] muxaddr_in,
  input  logic              muxaddr_valid,
  output logic              muxaddr_ready,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              gpio_strobe,
  output logic              busy,
  output logic              err_range,
  input  logic              err_clear
);

  localparam int MAX_CYC = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE);
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  // Handshake: a request transfers on a rising clk edge where muxaddr_valid and
  // muxaddr_ready are both high; ready is high exactly when the FSM is IDLE.
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [GPIO_W-1:0] gpio_nxt, code_bin, code;
  logic [ADDR_W-1:0] diff;
  logic              err_nxt, accept, in_range;

  assign diff     = muxaddr_in - BASE_A;
  // Upper diff bits must be zero for the code to fit in GPIO_W lines.
  assign in_range = (muxaddr_in >= BASE_A) && ((diff >> GPIO_W) == '0);
  assign code_bin = diff[GPIO_W-1:0];

`ifdef MUX_GPIO_GRAY_EN
  assign code = code_bin ^ (code_bin >> 1);
`else
  assign code = code_bin;
`endif

  assign muxaddr_ready = (state == IDLE);
  assign accept        = muxaddr_valid && muxaddr_ready;
  assign gpio_strobe   = (state == HOLD);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      gpio_out  <= '0;
      err_range <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gpio_out  <= gpio_nxt;
      err_range <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gpio_nxt  = gpio_out;
    err_nxt   = err_range;
    case (state)
      IDLE: begin
        if (accept && in_range && (code != gpio_out)) begin
          gpio_nxt  = code;
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LD;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Clear wins over a same-cycle range error; that error event is lost.
    if (err_clear) begin
      err_nxt = 1'b0;
    end else if (accept && !in_range) begin
      err_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_select_gpio_sequencer.sv
// Self-checking bench: directed test-plan cases plus random traffic against a countdown-based model.
module tb_mux_select_gpio_sequencer;

  localparam int S = 2;
  localparam int H = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] muxaddr_in = '0;
  logic       muxaddr_valid = 1'b0;
  logic       err_clear = 1'b0;
  logic       muxaddr_ready, gpio_strobe, busy, err_range;
  logic [3:0] gpio_out;

  logic [4:0] a3 = '0;
  logic       v3 = 1'b0;
  logic       c3 = 1'b0;
  logic       r3, s3, b3, e3;
  logic [2:0] g3;

  mux_select_gpio_sequencer dut (
    .clk(clk), .rst(rst), .muxaddr_in(muxaddr_in), .muxaddr_valid(muxaddr_valid),
    .muxaddr_ready(muxaddr_ready), .gpio_out(gpio_out), .gpio_strobe(gpio_strobe),
    .busy(busy), .err_range(err_range), .err_clear(err_clear)
  );

  mux_select_gpio_sequencer #(.GPIO_W(3)) dut3 (
    .clk(clk), .rst(rst), .muxaddr_in(a3), .muxaddr_valid(v3),
    .muxaddr_ready(r3), .gpio_out(g3), .gpio_strobe(s3),
    .busy(b3), .err_range(e3), .err_clear(c3)
  );

  // scoreboard state
  int n_vec  = 0;
  int n_miss = 0;
  logic [3:0] m_gpio = '0;
  logic       m_err  = 1'b0;
  int         m_left = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] enc(input logic [3:0] c);
`ifdef MUX_GPIO_GRAY_EN
    return c ^ (c >> 1);
`else
    return c;
`endif
  endfunction

  // Model: a request that changes the code makes the block busy for S+H edges;
  // the strobe is high during the last H of them.
  task automatic model_edge(input logic v, input logic [4:0] a, input logic c);
    int  d;
    bit  acc;
    acc = v && (m_left == 0);
    if (m_left > 0) m_left--;
    if (c) m_err = 1'b0;
    if (acc) begin
      d = int'(a) - 'h10;
      if (d < 0 || d >= 16) begin
        if (!c) m_err = 1'b1;
      end else if (enc(4'(d)) != m_gpio) begin
        m_gpio = enc(4'(d));
        m_left = S + H;
      end
    end
  endtask

  task automatic check_outputs();
    check("gpio_out", 32'(gpio_out), 32'(m_gpio));
    check("strobe", 32'(gpio_strobe), 32'(m_left > 0 && m_left <= H));
    check("busy", 32'(busy), 32'(m_left != 0));
    check("ready", 32'(muxaddr_ready), 32'(m_left == 0));
    check("err_range", 32'(err_range), 32'(m_err));
  endtask

  // driver: apply inputs at negedge, update model at posedge, sample #1 later
  task automatic step(input logic v, input logic [4:0] a, input logic c);
    @(negedge clk);
    muxaddr_valid = v;
    muxaddr_in    = a;
    err_clear     = c;
    @(posedge clk);
    model_edge(v, a, c);
    #1;
    check_outputs();
  endtask

  task automatic drain();
    int guard = 0;
    while (m_left != 0 && guard < 20) begin
      step(1'b0, 5'h00, 1'b0);
      guard++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gpio"}, 32'(gpio_out), 32'h0);
    check({tag, "_strobe"}, 32'(gpio_strobe), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_err"}, 32'(err_range), 32'h0);
    check({tag, "_ready"}, 32'(muxaddr_ready), 32'h1);
  endtask

  task automatic step3(input logic [4:0] a);
    @(negedge clk);
    v3 = 1'b1;
    a3 = a;
    @(posedge clk);
    #1;
    @(negedge clk);
    v3 = 1'b0;
    #1;
  endtask

  initial begin
    logic [3:0] prev;
    int         guard;
    logic [3:0] exp_1a;

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs();

    // 'h13: code 3, 2 cycles settle, 4 cycles strobe
    step(1'b1, 5'h13, 1'b0);
    check("h13_code", 32'(gpio_out), 32'(enc(4'h3)));
    for (int i = 0; i < S + H; i++) step(1'b0, 5'h00, 1'b0);
    // same code again: no sequence
    step(1'b1, 5'h13, 1'b0);
    check("h13_repeat_busy", 32'(busy), 32'h0);

    // out-of-range, sticky, then clear beating a simultaneous error
    step(1'b1, 5'h05, 1'b0);
    check("h05_err", 32'(err_range), 32'h1);
    step(1'b0, 5'h00, 1'b0);
    step(1'b1, 5'h05, 1'b1);
    check("clr_prio", 32'(err_range), 32'h0);

    // 'h12 then 'h1A held valid through the busy window
    step(1'b1, 5'h12, 1'b0);
    guard = 0;
    while (gpio_out != enc(4'hA) && guard < 12) begin
      step(1'b1, 5'h1A, 1'b0);
      guard++;
    end
    step(1'b0, 5'h00, 1'b0);
`ifdef MUX_GPIO_GRAY_EN
    exp_1a = 4'b1111;
`else
    exp_1a = 4'b1010;
`endif
    check("h1a_code", 32'(gpio_out), 32'(exp_1a));
    check("h1a_wait", 32'(guard), 32'(S + H + 1));
    drain();

    // reset in the middle of HOLD, with err_range set
    step(1'b1, 5'h05, 1'b0);
    step(1'b1, 5'h13, 1'b0);
    for (int i = 0; i < S + 1; i++) step(1'b0, 5'h00, 1'b0);
    check("in_hold", 32'(gpio_strobe), 32'h1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    m_gpio = '0; m_err = 1'b0; m_left = 0;
    @(posedge clk);
    #1;
    check_reset_values("rst_held");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs();

    // sweep the whole mapped range
    prev = gpio_out;
    for (int a = 'h10; a <= 'h1F; a++) begin
      step(1'b1, 5'(a), 1'b0);
      drain();
`ifdef MUX_GPIO_GRAY_EN
      if (a > 'h10) check("gray_step", 32'($countones(gpio_out ^ prev)), 32'h1);
`endif
      prev = gpio_out;
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 9) == 0));
    end
    drain();
    step(1'b0, 5'h00, 1'b1);

    // narrow instance: GPIO_W=3 maps only 'h10..'h17
    step3(5'h1F);
    check("w3_h1f_err", 32'(e3), 32'h1);
    check("w3_h1f_gpio", 32'(g3), 32'h0);
    step3(5'h05);
    check("w3_h05_err", 32'(e3), 32'h1);
    step3(5'h17);
`ifdef MUX_GPIO_GRAY_EN
    check("w3_h17_gpio", 32'(g3), 32'h4);
`else
    check("w3_h17_gpio", 32'(g3), 32'h7);
`endif
    check("w3_h17_busy", 32'(b3), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
